// File: rtl/pw_pattern_match.sv
// Masked byte-pattern matcher on the received USB byte stream (fe_clk domain).
// A hit disarms the block and pulses O_match; software must re-arm it for the next hit.
module pw_pattern_match #(
    parameter int pPATTERN_BYTES = 8,
    parameter int pLEN_WIDTH     = 4,
    parameter int pCOUNT_WIDTH   = 16
) (
    input  logic                        fe_clk,
    input  logic                        reset_n,
    input  logic                        I_arm,
    input  logic                        I_disarm,
    input  logic [8*pPATTERN_BYTES-1:0] I_pattern,
    input  logic [8*pPATTERN_BYTES-1:0] I_mask,
    input  logic [pLEN_WIDTH-1:0]       I_pattern_bytes,
    input  logic                        I_rx_active,
    input  logic                        I_rx_valid,
    input  logic [7:0]                  I_rx_data,
    output logic                        O_match,
    output logic                        O_armed,
    output logic [pCOUNT_WIDTH-1:0]     O_match_count
);

    localparam int N  = pPATTERN_BYTES;
    localparam int HW = (N > 1) ? 8 * (N - 1) : 8;
    localparam logic [pLEN_WIDTH-1:0] FILL_MAX = pLEN_WIDTH'(N);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t                    state_r;
    logic [HW-1:0]             hist_r;
    logic [pLEN_WIDTH-1:0]     fill_r;
    logic                      match_r;
    logic                      armed_r;
    logic [pCOUNT_WIDTH-1:0]   match_cnt_r;

    logic [8*N-1:0]            cand_s;
    logic [N-1:0]              byte_ok_s;
    logic                      accepted_s;
    logic                      len_ok_s;
    logic                      fill_ok_s;
    logic                      hit_s;

    function automatic logic byte_match(input logic [7:0] cand,
                                        input logic [7:0] pat,
                                        input logic [7:0] mask);
        return ((cand ^ pat) & mask) == 8'h00;
    endfunction

    // Candidate window: newest byte is the one on the bus this cycle, older bytes come from history.
    if (N > 1) begin : g_cand_multi
        assign cand_s = {hist_r, I_rx_data};
    end else begin : g_cand_single
        assign cand_s = I_rx_data;
    end

    for (genvar k = 0; k < N; k++) begin : g_cmp
        localparam logic [pLEN_WIDTH-1:0] K_IDX = pLEN_WIDTH'(k);
        // Bytes at or beyond the programmed length never block a hit.
        assign byte_ok_s[k] = (K_IDX >= I_pattern_bytes)
                            | byte_match(cand_s[8*k +: 8], I_pattern[8*k +: 8], I_mask[8*k +: 8]);
    end

    // Qualify the window compare into a single hit for this cycle.
    always_comb begin
        accepted_s = I_rx_valid & I_rx_active;
        len_ok_s   = (I_pattern_bytes != {pLEN_WIDTH{1'b0}}) && (I_pattern_bytes <= FILL_MAX);
        fill_ok_s  = ({1'b0, fill_r} + {{pLEN_WIDTH{1'b0}}, 1'b1}) >= {1'b0, I_pattern_bytes};
        if ((state_r == ARMED) && !I_disarm) begin
            hit_s = accepted_s & len_ok_s & fill_ok_s & (&byte_ok_s);
        end else begin
            hit_s = 1'b0;
        end
    end

    // History, fill tracking, arm/disarm FSM and registered match outputs.
    always_ff @(posedge fe_clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            hist_r      <= {HW{1'b0}};
            fill_r      <= {pLEN_WIDTH{1'b0}};
            match_r     <= 1'b0;
            armed_r     <= 1'b0;
            match_cnt_r <= {pCOUNT_WIDTH{1'b0}};
        end else begin
            match_r <= 1'b0;
            if (!I_rx_active) begin
                fill_r <= {pLEN_WIDTH{1'b0}};
            end else if (I_rx_valid) begin
                hist_r <= cand_s[HW-1:0];
                if (fill_r < FILL_MAX) begin
                    fill_r <= fill_r + pLEN_WIDTH'(1);
                end else begin
                    fill_r <= fill_r;
                end
            end else begin
                fill_r <= fill_r;
            end
            case (state_r)
                IDLE: begin
                    if (I_arm && !I_disarm) begin
                        state_r <= ARMED;
                        armed_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        armed_r <= 1'b0;
                    end
                end
                ARMED: begin
                    if (I_disarm) begin
                        state_r <= IDLE;
                        armed_r <= 1'b0;
                    end else if (hit_s) begin
                        state_r <= IDLE;
                        armed_r <= 1'b0;
                        match_r <= 1'b1;
                        if (match_cnt_r != {pCOUNT_WIDTH{1'b1}}) begin
                            match_cnt_r <= match_cnt_r + pCOUNT_WIDTH'(1);
                        end else begin
                            match_cnt_r <= match_cnt_r;
                        end
                    end else begin
                        state_r <= ARMED;
                        armed_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    armed_r <= 1'b0;
                end
            endcase
        end
    end

    assign O_match       = match_r;
    assign O_armed       = armed_r;
    assign O_match_count = match_cnt_r;

endmodule
